// File: rtl/rf_read_stage_p.sv
// Register-fetch stage: holds one instruction, resolves rs/rt through forwarding and writeback bypass.
// Optional perf counters (stall_cnt_o, ins_cnt_o) when RF_PERF_CNT_EN is defined.
//   state   | meaning
//   EMPTY   | no instruction held
//   READY   | instruction held, operands resolved, presented downstream
//   STALL   | instruction held, a selected forwarding source is still pending
module rf_read_stage_p #(
  parameter int DATA_W    = 32,
  parameter int AW        = 5,
  parameter int NFWD      = 2,
  parameter int STALL_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          ins_i,
  input  logic [DATA_W-1:0]    pc_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          ins_o,
  output logic [DATA_W-1:0]    pc_o,
  output logic [AW-1:0]        rs_n_o,
  output logic [AW-1:0]        rt_n_o,
  output logic [DATA_W-1:0]    rs_o,
  output logic [DATA_W-1:0]    rt_o,
  input  logic                 wb_we_i,
  input  logic [AW-1:0]        wb_addr_i,
  input  logic [DATA_W-1:0]    wb_din_i,
  input  logic [NFWD-1:0]      fw_valid_i,
  input  logic [NFWD-1:0]      fw_pend_i,
  input  logic [NFWD*AW-1:0]   fw_addr_i,
  input  logic [NFWD*DATA_W-1:0] fw_data_i,
  output logic                 err_o
`ifdef RF_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          ins_cnt_o
`endif
);

  localparam int NREG = 1 << AW;
  localparam int SW   = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(STALL_MAX);

  typedef enum logic [1:0] {S_EMPTY, S_READY, S_STALL} state_t;

  state_t              state_q, state_d, state_cur;
  logic [31:0]         ins_q, ins_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [AW-1:0]       rs_n_q, rs_n_d, rt_n_q, rt_n_d;
  logic [SW-1:0]       stall_q, stall_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rf_q [NREG];
  logic [DATA_W-1:0]   rf_d [NREG];

  logic [AW-1:0]       op_idx  [2];
  logic [DATA_W-1:0]   op_val  [2];
  logic [1:0]          op_pend;
  logic                op_hit;
  logic                hazard, fire, capture;

  always_comb begin
    rf_d = rf_q;
    if (wb_we_i && (wb_addr_i != '0)) rf_d[wb_addr_i] = wb_din_i;
  end

  // Youngest matching forwarding source wins; its pend bit alone decides the hazard.
  always_comb begin
    op_idx[0] = rs_n_q;
    op_idx[1] = rt_n_q;
    op_pend   = '0;
    op_hit    = 1'b0;
    for (int o = 0; o < 2; o++) begin
      op_val[o] = '0;
      op_hit    = 1'b0;
      if (op_idx[o] != '0) begin
        for (int k = 0; k < NFWD; k++) begin
          if (!op_hit && fw_valid_i[k] && (fw_addr_i[k*AW +: AW] == op_idx[o])) begin
            op_hit     = 1'b1;
            op_val[o]  = fw_data_i[k*DATA_W +: DATA_W];
            op_pend[o] = fw_pend_i[k];
          end
        end
        if (!op_hit) begin
          if (wb_we_i && (wb_addr_i == op_idx[o])) op_val[o] = wb_din_i;
          else                                     op_val[o] = rf_q[op_idx[o]];
        end
      end
    end
  end

  always_comb begin
    hazard      = (state_q != S_EMPTY) && (|op_pend);
    state_cur   = (state_q == S_EMPTY) ? S_EMPTY : (hazard ? S_STALL : S_READY);
    out_valid_o = (state_cur == S_READY) && !flush_i;
    fire        = out_valid_o && out_ready_i;
    in_ready_o  = !flush_i && ((state_cur == S_EMPTY) || fire);
    capture     = in_valid_i && in_ready_o;

    state_d = state_cur;
    ins_d   = ins_q;
    pc_d    = pc_q;
    rs_n_d  = rs_n_q;
    rt_n_d  = rt_n_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else if (capture) begin
      state_d = S_READY;
      ins_d   = ins_i;
      pc_d    = pc_i;
      rs_n_d  = ins_i[21 +: AW];
      rt_n_d  = ins_i[16 +: AW];
    end else if (fire) begin
      state_d = S_EMPTY;
    end

    stall_d = '0;
    if (!flush_i && (state_cur == S_STALL)) stall_d = (stall_q == SMAX) ? stall_q : stall_q + 1'b1;
    err_d = err_q || ((STALL_MAX != 0) && (stall_d == SMAX));
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_EMPTY;
      ins_q   <= '0;
      pc_q    <= '0;
      rs_n_q  <= '0;
      rt_n_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      pc_q    <= pc_d;
      rs_n_q  <= rs_n_d;
      rt_n_q  <= rt_n_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      rf_q    <= rf_d;
    end
  end

  assign ins_o  = ins_q;
  assign pc_o   = pc_q;
  assign rs_n_o = rs_n_q;
  assign rt_n_o = rt_n_q;
  assign rs_o   = op_val[0];
  assign rt_o   = op_val[1];
  assign err_o  = err_q;

`ifdef RF_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_ins_q, perf_ins_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_ins_d   = perf_ins_q;
    if (!flush_i && (state_cur == S_STALL) && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
    if (fire && (perf_ins_q != 32'hFFFF_FFFF))
      perf_ins_d = perf_ins_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_stall_q <= '0;
      perf_ins_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_ins_q   <= perf_ins_d;
    end
  end

  assign stall_cnt_o = perf_stall_q;
  assign ins_cnt_o   = perf_ins_q;
`endif

endmodule

// File: tb/tb_rf_read_stage_p.sv
// Scoreboard bench for rf_read_stage_p: expected operands queued at issue, compared at fire-out.
module tb_rf_read_stage_p;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] ins_i, pc_i, ins_o, pc_o, rs_o, rt_o;
  logic [4:0]  rs_n_o, rt_n_o, wb_addr_i;
  logic        wb_we_i, err_o;
  logic [31:0] wb_din_i;
  logic [1:0]  fw_valid_i, fw_pend_i;
  logic [9:0]  fw_addr_i;
  logic [63:0] fw_data_i;
`ifdef RF_PERF_CNT_EN
  logic [31:0] stall_cnt_o, ins_cnt_o;
`endif

  always #5 clk = ~clk;

  rf_read_stage_p dut (
    .clk(clk), .rst_n_i(rst_n_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .ins_i(ins_i), .pc_i(pc_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ins_o(ins_o), .pc_o(pc_o), .rs_n_o(rs_n_o), .rt_n_o(rt_n_o), .rs_o(rs_o), .rt_o(rt_o),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_din_i(wb_din_i),
    .fw_valid_i(fw_valid_i), .fw_pend_i(fw_pend_i), .fw_addr_i(fw_addr_i), .fw_data_i(fw_data_i),
    .err_o(err_o)
`ifdef RF_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .ins_cnt_o(ins_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0;
  int   fire_cnt = 0;
  int   last_fire_cyc = -10;
  int   run_len = 0;
  int   issued_cnt = 0;
  int   f0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'h23, rs, rt, imm};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n_i && out_valid_o && out_ready_i) begin
      exp_t e;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("fire_ins", ins_o, e.ins);
        check("fire_pc", pc_o, e.pc);
        check("fire_rs", rs_o, e.rs);
        check("fire_rt", rt_o, e.rt);
      end
      fire_cnt++;
      run_len = (cyc == last_fire_cyc + 1) ? run_len + 1 : 1;
      last_fire_cyc = cyc;
    end
  end

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we_i = 1'b1; wb_addr_i = a; wb_din_i = d;
    @(posedge clk); #1;
    wb_we_i = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the capturing edge.
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] pc,
                       input logic [31:0] exp_rs, input logic [31:0] exp_rt);
    exp_t e;
    int n = 0;
    in_valid_i = 1'b1;
    ins_i = mk_ins(rs, rt, pc[15:0]);
    pc_i  = pc;
    @(negedge clk);
    while (!in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("issue_accept", 64'(in_ready_o), 64'd1);
    e.ins = ins_i; e.pc = pc; e.rs = exp_rs; e.rt = exp_rt;
    sb.push_back(e);
    issued_cnt++;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0; in_valid_i = 0; ins_i = 0; pc_i = 0; flush_i = 0; out_ready_i = 0;
    wb_we_i = 0; wb_addr_i = 0; wb_din_i = 0;
    fw_valid_i = 0; fw_pend_i = 0; fw_addr_i = 0; fw_data_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_ready", 64'(in_ready_o), 64'd1);
    check("rst_ins", ins_o, 64'd0);
    check("rst_pc", pc_o, 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    @(posedge clk); #1;
    rst_n_i = 1'b1;

    // array read after writeback
    wb_write(5'd5, 32'hDEADBEEF);
    out_ready_i = 1'b1;
    issue(5'd5, 5'd0, 32'h100, 32'hDEADBEEF, 32'h0);
    @(negedge clk);
    check("s1_valid", 64'(out_valid_o), 64'd1);
    check("s1_rs", rs_o, 64'hDEADBEEF);
    check("s1_rt", rt_o, 64'h0);
    check("s1_rs_n", 64'(rs_n_o), 64'd5);
    @(posedge clk); #1;

    // forwarding priority
    wb_write(5'd5, 32'h11);
    fw_valid_i = 2'b11; fw_addr_i = {5'd5, 5'd5}; fw_data_i = {32'h22, 32'h33};
    out_ready_i = 1'b0;
    issue(5'd5, 5'd0, 32'h104, 32'h22, 32'h0);
    @(negedge clk);
    check("s2_fw0", rs_o, 64'h33);
    check("s2_inrdy", 64'(in_ready_o), 64'd0);
    @(posedge clk); #1;
    fw_valid_i = 2'b10;
    @(negedge clk);
    check("s2_fw1", rs_o, 64'h22);
    check("s2_hold_pc", pc_o, 64'h104);
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    fw_valid_i = 2'b00;

    // load-use stall for three cycles
    fw_valid_i = 2'b01; fw_addr_i = {5'd0, 5'd7}; fw_pend_i = 2'b01; fw_data_i = 64'h0;
    issue(5'd0, 5'd7, 32'h108, 32'h0, 32'h44);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s3_stall_valid", 64'(out_valid_o), 64'd0);
      check("s3_stall_ready", 64'(in_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    fw_pend_i = 2'b00; fw_data_i = {32'h0, 32'h44};
    @(negedge clk);
    check("s3_release_valid", 64'(out_valid_o), 64'd1);
    check("s3_release_rt", rt_o, 64'h44);
    @(posedge clk); #1;

    // younger non-pending match masks an older pending one
    fw_valid_i = 2'b11; fw_addr_i = {5'd7, 5'd7}; fw_pend_i = 2'b10; fw_data_i = {32'h99, 32'h55};
    issue(5'd0, 5'd7, 32'h10C, 32'h0, 32'h55);
    @(negedge clk);
    check("s3_mask_valid", 64'(out_valid_o), 64'd1);
    @(posedge clk); #1;
    fw_valid_i = 2'b00; fw_pend_i = 2'b00; fw_data_i = 64'h0;

    // back-to-back stream
    f0 = fire_cnt;
    for (int i = 0; i < 4; i++)
      issue(5'd5, 5'(i + 1), 32'h200 + 32'(4 * i), 32'h11, 32'h0);
    @(negedge clk); #1;
    check("s4_fires", 64'(fire_cnt - f0), 64'd4);
    check("s4_consecutive", 64'(run_len), 64'd4);
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    issue(5'd3, 5'd0, 32'h300, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("s4_hold_ins", ins_o, 64'(mk_ins(5'd3, 5'd0, 16'h0300)));
      check("s4_hold_pc", pc_o, 64'h300);
      check("s4_hold_ready", 64'(in_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    // watchdog and flush
    fw_valid_i = 2'b01; fw_addr_i = {5'd0, 5'd9}; fw_pend_i = 2'b01;
    issue(5'd9, 5'd0, 32'h400, 32'h0, 32'h0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("s5_err_before", 64'(err_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("s5_err_set", 64'(err_o), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("s5_err_sticky", 64'(err_o), 64'd1);
    @(posedge clk); #1;
    flush_i = 1'b1; in_valid_i = 1'b1; ins_i = mk_ins(5'd1, 5'd1, 16'h0444); pc_i = 32'h444;
    @(negedge clk);
    check("s5_flush_valid", 64'(out_valid_o), 64'd0);
    check("s5_flush_ready", 64'(in_ready_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    fw_valid_i = 2'b00; fw_pend_i = 2'b00;
    @(negedge clk);
    check("s5_empty_valid", 64'(out_valid_o), 64'd0);
    check("s5_empty_ready", 64'(in_ready_o), 64'd1);
    check("s5_err_after_flush", 64'(err_o), 64'd1);
    void'(sb.pop_back());
    issued_cnt--;
    @(posedge clk); #1;

    // r0 is hardwired zero; same-cycle writeback bypass
    wb_we_i = 1'b1; wb_addr_i = 5'd0; wb_din_i = 32'hFFFF;
    issue(5'd0, 5'd0, 32'h500, 32'h0, 32'h0);
    @(negedge clk);
    check("s6_r0", rs_o, 64'h0);
    @(posedge clk); #1;
    wb_addr_i = 5'd6; wb_din_i = 32'h66;
    issue(5'd6, 5'd0, 32'h504, 32'h66, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    wb_we_i = 1'b0;
    issue(5'd6, 5'd0, 32'h508, 32'h66, 32'h0);
    @(negedge clk); #1;
`ifdef RF_PERF_CNT_EN
    check("perf_ins_cnt", ins_cnt_o, 64'(issued_cnt));
`endif
    check("err_before_reset", 64'(err_o), 64'd1);
    @(posedge clk); #1;

    // asynchronous reset while holding an instruction
    out_ready_i = 1'b0;
    issue(5'd5, 5'd0, 32'h600, 32'h11, 32'h0);
    void'(sb.pop_back());
    @(negedge clk); #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid_o), 64'd0);
    check("arst_err", 64'(err_o), 64'd0);
    check("arst_ins", ins_o, 64'd0);
    check("arst_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    out_ready_i = 1'b1;
    issue(5'd5, 5'd0, 32'h700, 32'h0, 32'h0);
    @(negedge clk); #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_read_stage_p.md
Name: rf_read_stage_p

Overview:
- Parametrised register-fetch stage for the mips789 pipeline; successor of the fixed 32-bit register-read stage.
- Holds one decoded instruction in a valid/ready stage register and reads rs/rt from an internal register array.
- Resolves operands through an N-source forwarding network plus same-cycle writeback bypass.
- Interlocks on pending (load-use) producers; a watchdog flags stalls that never resolve.

Parameters:
DATA_W, 32, operand/PC width
AW, 5, register index width (1..5); 2**AW registers, reg 0 hardwired zero
NFWD, 2, number of forwarding sources; index 0 = youngest, highest priority
STALL_MAX, 15, consecutive hazard cycles before err_o; 0 disables watchdog

Ports:
clk  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
in_valid_i  in  1  upstream instruction valid
in_ready_o  out  1  stage can accept
ins_i  in  32  instruction word
pc_i  in  DATA_W  instruction PC
flush_i  in  1  discard stage contents
out_valid_o  out  1  operands resolved, instruction presented
out_ready_i  in  1  downstream accepts
ins_o  out  32  held instruction
pc_o  out  DATA_W  held PC
rs_n_o, rt_n_o  out  AW  held source indices
rs_o, rt_o  out  DATA_W  resolved operands
wb_we_i  in  1  writeback enable
wb_addr_i  in  AW  writeback index
wb_din_i  in  DATA_W  writeback data
fw_valid_i  in  NFWD  source k holds a destination
fw_pend_i  in  NFWD  source k data not yet available
fw_addr_i  in  NFWD*AW  packed destination indices
fw_data_i  in  NFWD*DATA_W  packed forwarded data
err_o  out  1  sticky stall-watchdog error

Behaviour:
- Reset: stage EMPTY; ins_o, pc_o, rs_n_o, rt_n_o = 0; out_valid_o = 0; err_o = 0; stall counter = 0; all array registers = 0.
- Field decode: rs = ins[21+AW-1:21], rt = ins[16+AW-1:16], i.e. the low AW bits of the 5-bit fields.
- Array:
  - Write on rising clk when wb_we_i && wb_addr_i != 0.
  - Writes to index 0 are ignored; index 0 always reads 0.
- Operand resolution (combinational, from held rs/rt), for each operand with index r:
  - r == 0 gives 0.
  - Otherwise the lowest k with fw_valid_i[k] && fw_addr[k] == r selects fw_data[k].
  - Otherwise wb_we_i && wb_addr_i == r gives wb_din_i.
  - Otherwise the array value.
- Hazard:
  - Asserted when stage FULL and the selected forwarding source for rs or rt (nonzero) has fw_pend_i set.
  - A younger non-pending match masks an older pending one.
- FSM states:
  - EMPTY: out_valid_o = 0.
  - READY: FULL, no hazard, out_valid_o = 1.
  - STALL: FULL with hazard, out_valid_o = 0.
  - READY/STALL are re-evaluated every cycle from the combinational hazard.
- Handshake:
  - in_ready_o = !flush_i && (EMPTY || (out_valid_o && out_ready_i)).
  - Capture on in_valid_i && in_ready_o.
  - Simultaneous fire-out and capture: the new instruction replaces the old with no bubble.
  - Fire-out without capture goes to EMPTY.
  - Held data is stable while out_valid_o && !out_ready_i.
- flush_i:
  - Forces out_valid_o = 0 that cycle; stage becomes EMPTY next cycle; no capture that cycle.
  - Flush beats capture; the stall counter clears.
- Watchdog:
  - Counter increments each STALL cycle and clears otherwise.
  - When it reaches STALL_MAX, err_o sets and stays set until reset.
  - The counter saturates.
- Asynchronous reset mid-operation returns everything to reset values immediately; there is no partial state.

Optional Feature:
- Macro RF_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o[31:0] and ins_cnt_o[31:0].
  - stall_cnt_o counts STALL cycles; ins_cnt_o counts fire-out handshakes.
  - Both are saturating at 32'hFFFFFFFF and reset to 0.
  - flush cycles are not counted.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write 0xDEADBEEF to r5 (wb), then present ins with rs=5, rt=0 and out_ready_i=1 -> next cycle out_valid_o=1, rs_o=0xDEADBEEF, rt_o=0.
- Hold r5=0x11 in array, fw1 addr 5 data 0x22, fw0 addr 5 data 0x33, all non-pending -> rs_o=0x33; drop fw0 valid -> rs_o=0x22.
- fw0 addr 7 pending for 3 cycles, instruction rt=7 -> out_valid_o=0 for 3 cycles, in_ready_o=0; pend clears with data 0x44 -> out_valid_o=1, rt_o=0x44.
- Back-to-back stream of 4 instructions with out_ready_i=1 -> 4 fires in 4 consecutive cycles; toggle out_ready_i=0 -> ins_o/pc_o held, in_ready_o=0.
- Permanent pending hazard with STALL_MAX=15 -> err_o rises after 15th stall cycle and stays 1; flush_i -> stage EMPTY next cycle, err_o still 1 until rst_n_i low.
- wb_we_i to r0 with 0xFFFF, then read rs=0 -> rs_o=0; with RF_PERF_CNT_EN, after the previous scenarios ins_cnt_o equals the fire count.
